serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 13 +
 rtl/full_adder.sv | 14 +
 rtl/serial_adder_ctrl.sv | 120 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
// Imported by the controller and its testbench.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sa_state_t;

   localparam int SA_WIDTH_DEF = 8;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell.
// Reused by the serial adder as its only arithmetic datapath.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder stepped LSB first over WIDTH cycles.
// Operands accepted in IDLE, result held in DONE until the consumer takes it.
module serial_adder_ctrl
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = SA_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH);

   if (WIDTH < 2) begin : g_bad_width
      $error("serial_adder_ctrl: WIDTH must be >= 2");
   end

   sa_state_t        state;
   sa_state_t        state_nxt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_sh;
   logic             carry;
   logic [CNT_W-1:0] cnt;
   logic             fa_s;
   logic             fa_cout;
   logic             accept;
   logic             last;

   full_adder u_fa (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .cin  (carry),
      .s    (fa_s),
      .cout (fa_cout)
   );

   // cnt counts bits already done; the bit with cnt == WIDTH-1 is the last.
   assign last = (cnt == CNT_W'(WIDTH - 1));

   // State register; reset aborts any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and handshake outputs; unknown encodings fall back to IDLE.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (last) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Operand load on accept, one bit per cycle in RUN, hold otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh   <= '0;
         b_sh   <= '0;
         sum_sh <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
      end else if (accept) begin
         a_sh   <= a;
         b_sh   <= b;
         sum_sh <= '0;
         carry  <= cin;
         cnt    <= '0;
      end else if (state == RUN) begin
         a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
         b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
         sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
         carry  <= fa_cout;
         cnt    <= cnt + CNT_W'(1);
      end
   end

   // Partial results never leave the block.
   assign sum  = out_valid ? sum_sh : '0;
   assign cout = out_valid ? carry  : 1'b0;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH=8 and WIDTH=4.
// Expected results are queued on stimulus and compared on output.
module tb_serial_adder_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   logic       iv8, ir8, ov8, or8, ci8, co8, bz8;
   logic [7:0] a8, b8, s8;
   logic       iv4, ir4, ov4, or4, ci4, co4, bz4;
   logic [3:0] a4, b4, s4;

   int tests = 0;
   int fails = 0;

   logic [8:0] q8[$];
   logic [4:0] q4[$];

   serial_adder_ctrl #(.WIDTH(8)) u_d8 (
      .clk(clk), .rst(rst),
      .in_valid(iv8), .in_ready(ir8),
      .a(a8), .b(b8), .cin(ci8),
      .out_valid(ov8), .out_ready(or8),
      .sum(s8), .cout(co8), .busy(bz8)
   );

   serial_adder_ctrl #(.WIDTH(4)) u_d4 (
      .clk(clk), .rst(rst),
      .in_valid(iv4), .in_ready(ir4),
      .a(a4), .b(b4), .cin(ci4),
      .out_valid(ov4), .out_ready(or4),
      .sum(s4), .cout(co4), .busy(bz4)
   );

   // Runs one WIDTH=8 operation with out_ready high; returns result and latency.
   task automatic do_op8(input logic [7:0] a, input logic [7:0] b,
                         input logic ci, output logic [8:0] res,
                         output int lat);
      or8 = 1'b1;
      a8 = a; b8 = b; ci8 = ci; iv8 = 1'b1;
      q8.push_back({1'b0, a} + {1'b0, b} + {8'd0, ci});
      @(posedge clk); #1;
      iv8 = 1'b0;
      lat = -1;
      res = 'x;
      for (int c = 1; c <= 30; c++) begin
         @(posedge clk); #1;
         if (ov8) begin
            lat = c;
            res = {co8, s8};
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      logic [8:0] exp;
      rst = 1'b1;
      #1;
      tests++;
      if (ir8 !== 1'b1 || ov8 !== 1'b0 || bz8 !== 1'b0 ||
          s8 !== 8'h00 || co8 !== 1'b0) begin
         fails++;
         $display("FAIL reset_init: ir=%b ov=%b busy=%b sum=%h cout=%b, need 1 0 0 00 0",
                  ir8, ov8, bz8, s8, co8);
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      or8 = 1'b0;
      a8 = 8'h12; b8 = 8'h34; ci8 = 1'b1; iv8 = 1'b1;
      q8.push_back(9'h047);
      @(posedge clk); #1;
      iv8 = 1'b0;
      for (int c = 0; c < 20 && !ov8; c++) begin
         @(posedge clk); #1;
      end
      tests++;
      exp = q8.pop_front();
      if (ov8 !== 1'b1 || {co8, s8} !== exp) begin
         fails++;
         $display("FAIL reset_done_setup: ov=%b res=%h, need 1 %h", ov8, {co8, s8}, exp);
      end
      #2 rst = 1'b1;
      #1;
      tests++;
      if (ir8 !== 1'b1 || ov8 !== 1'b0 || bz8 !== 1'b0 ||
          s8 !== 8'h00 || co8 !== 1'b0) begin
         fails++;
         $display("FAIL reset_async: ir=%b ov=%b busy=%b sum=%h cout=%b, need 1 0 0 00 0",
                  ir8, ov8, bz8, s8, co8);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      or8 = 1'b1;
   endtask

   task automatic test_basic();
      logic [8:0] got;
      logic [8:0] exp;
      int lat;
      int bcnt;
      or8 = 1'b1;
      a8 = 8'h5A; b8 = 8'h33; ci8 = 1'b0; iv8 = 1'b1;
      q8.push_back(9'h08D);
      @(posedge clk); #1;
      iv8 = 1'b0;
      lat = -1; bcnt = 0; got = 'x;
      for (int c = 0; c <= 12; c++) begin
         if (c > 0) begin
            @(posedge clk); #1;
         end
         if (bz8) bcnt++;
         if (ov8 && lat < 0) begin
            lat = c;
            got = {co8, s8};
         end
      end
      exp = q8.pop_front();
      tests++;
      if (lat != 8) begin
         fails++;
         $display("FAIL basic_latency: got %0d, need 8", lat);
      end
      tests++;
      if (bcnt != 9) begin
         fails++;
         $display("FAIL basic_busy: got %0d cycles, need 9", bcnt);
      end
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL basic_sum: got %h, need %h", got, exp);
      end
   endtask

   task automatic test_carry();
      logic [8:0] res;
      logic [8:0] exp;
      int lat;
      logic [24:0] vec[3];
      vec[0] = {8'hFF, 8'h01, 1'b0, 8'h00};
      vec[1] = {8'hFF, 8'h00, 1'b1, 8'h00};
      vec[2] = {8'hFF, 8'hFF, 1'b1, 8'h00};
      for (int i = 0; i < 3; i++) begin
         do_op8(vec[i][24:17], vec[i][16:9], vec[i][8], res, lat);
         exp = q8.pop_front();
         tests++;
         if (res !== exp || lat != 8) begin
            fails++;
            $display("FAIL carry_%0d: got %h lat %0d, need %h lat 8", i, res, lat, exp);
         end
      end
      tests++;
      if (res !== 9'h1FF) begin
         fails++;
         $display("FAIL carry_ff_ff_1: got %h, need 1ff", res);
      end
   endtask

   task automatic test_backpressure();
      logic [8:0] exp;
      int lat;
      or8 = 1'b0;
      a8 = 8'h9C; b8 = 8'h71; ci8 = 1'b0; iv8 = 1'b1;
      q8.push_back(9'h10D);
      @(posedge clk); #1;
      a8 = 8'hC3; b8 = 8'h3C; ci8 = 1'b1;
      q8.push_back(9'h100);
      for (int c = 0; c < 20 && !ov8; c++) begin
         @(posedge clk); #1;
      end
      exp = q8.pop_front();
      for (int c = 0; c < 5; c++) begin
         tests++;
         if (ov8 !== 1'b1 || ir8 !== 1'b0 || {co8, s8} !== exp) begin
            fails++;
            $display("FAIL bp_hold_%0d: ov=%b ir=%b res=%h, need 1 0 %h",
                     c, ov8, ir8, {co8, s8}, exp);
         end
         @(posedge clk); #1;
      end
      or8 = 1'b1;
      @(posedge clk); #1;
      tests++;
      if (ir8 !== 1'b1 || ov8 !== 1'b0 || bz8 !== 1'b0) begin
         fails++;
         $display("FAIL bp_release: ir=%b ov=%b busy=%b, need 1 0 0", ir8, ov8, bz8);
      end
      @(posedge clk); #1;
      iv8 = 1'b0;
      tests++;
      if (bz8 !== 1'b1 || ir8 !== 1'b0) begin
         fails++;
         $display("FAIL bp_reaccept: busy=%b ir=%b, need 1 0", bz8, ir8);
      end
      lat = -1;
      for (int c = 1; c <= 30 && lat < 0; c++) begin
         @(posedge clk); #1;
         if (ov8) lat = c;
      end
      exp = q8.pop_front();
      tests++;
      if (lat != 8 || {co8, s8} !== exp) begin
         fails++;
         $display("FAIL bp_second: got %h lat %0d, need %h lat 8", {co8, s8}, lat, exp);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_run();
      logic [8:0] res;
      logic [8:0] exp;
      int lat;
      int ovc;
      or8 = 1'b1;
      a8 = 8'hAA; b8 = 8'h55; ci8 = 1'b0; iv8 = 1'b1;
      @(posedge clk); #1;
      iv8 = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      tests++;
      if (ov8 !== 1'b0 || bz8 !== 1'b0 || ir8 !== 1'b1 || s8 !== 8'h00) begin
         fails++;
         $display("FAIL abort_run: ov=%b busy=%b ir=%b sum=%h, need 0 0 1 00",
                  ov8, bz8, ir8, s8);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      ovc = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (ov8) ovc++;
      end
      tests++;
      if (ovc != 0) begin
         fails++;
         $display("FAIL abort_no_result: out_valid seen %0d cycles, need 0", ovc);
      end
      do_op8(8'h10, 8'h20, 1'b1, res, lat);
      exp = q8.pop_front();
      tests++;
      if (res !== exp || lat != 8) begin
         fails++;
         $display("FAIL after_abort: got %h lat %0d, need %h lat 8", res, lat, exp);
      end
   endtask

   task automatic test_random8(input int n);
      int rcv;
      rcv = 0;
      fork
         begin : drv
            logic [8:0] e;
            logic acc;
            for (int i = 0; i < n; i++) begin
               repeat ($urandom_range(0, 2)) @(posedge clk);
               #1;
               a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
               e = {1'b0, a8} + {1'b0, b8} + {8'd0, ci8};
               iv8 = 1'b1;
               acc = 1'b0;
               for (int w = 0; w < 100 && !acc; w++) begin
                  acc = ir8;
                  @(posedge clk); #1;
               end
               iv8 = 1'b0;
               if (acc) q8.push_back(e);
               else begin
                  tests++; fails++;
                  $display("FAIL rnd8_accept: op %0d not accepted, need accept", i);
               end
            end
         end
         begin : mon
            logic fire;
            logic [8:0] obs;
            logic [8:0] e;
            for (int c = 0; c < 20000 && rcv < n; c++) begin
               or8 = ($urandom_range(0, 3) != 0);
               fire = ov8 && or8;
               obs = {co8, s8};
               tests++;
               if (!ov8 && obs !== 9'h000) begin
                  fails++;
                  $display("FAIL rnd8_gate: res=%h while idle, need 000", obs);
               end
               @(posedge clk); #1;
               if (fire) begin
                  rcv++;
                  e = (q8.size() > 0) ? q8.pop_front() : 'x;
                  tests++;
                  if (obs !== e) begin
                     fails++;
                     $display("FAIL rnd8_result %0d: got %h, need %h", rcv, obs, e);
                  end
               end
            end
         end
      join
      or8 = 1'b1;
      tests++;
      if (rcv != n || q8.size() != 0) begin
         fails++;
         $display("FAIL rnd8_count: got %0d results %0d queued, need %0d 0",
                  rcv, q8.size(), n);
      end
   endtask

   task automatic test_random4(input int n);
      int rcv;
      rcv = 0;
      fork
         begin : drv
            logic [4:0] e;
            logic acc;
            for (int i = 0; i < n; i++) begin
               repeat ($urandom_range(0, 2)) @(posedge clk);
               #1;
               a4 = 4'($urandom); b4 = 4'($urandom); ci4 = 1'($urandom);
               e = {1'b0, a4} + {1'b0, b4} + {4'd0, ci4};
               iv4 = 1'b1;
               acc = 1'b0;
               for (int w = 0; w < 100 && !acc; w++) begin
                  acc = ir4;
                  @(posedge clk); #1;
               end
               iv4 = 1'b0;
               if (acc) q4.push_back(e);
               else begin
                  tests++; fails++;
                  $display("FAIL rnd4_accept: op %0d not accepted, need accept", i);
               end
            end
         end
         begin : mon
            logic fire;
            logic [4:0] obs;
            logic [4:0] e;
            for (int c = 0; c < 20000 && rcv < n; c++) begin
               or4 = ($urandom_range(0, 3) != 0);
               fire = ov4 && or4;
               obs = {co4, s4};
               tests++;
               if (!ov4 && obs !== 5'h00) begin
                  fails++;
                  $display("FAIL rnd4_gate: res=%h while idle, need 00", obs);
               end
               @(posedge clk); #1;
               if (fire) begin
                  rcv++;
                  e = (q4.size() > 0) ? q4.pop_front() : 'x;
                  tests++;
                  if (obs !== e) begin
                     fails++;
                     $display("FAIL rnd4_result %0d: got %h, need %h", rcv, obs, e);
                  end
               end
            end
         end
      join
      or4 = 1'b1;
      tests++;
      if (rcv != n || q4.size() != 0) begin
         fails++;
         $display("FAIL rnd4_count: got %0d results %0d queued, need %0d 0",
                  rcv, q4.size(), n);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, need finish");
      $fatal(1, "watchdog");
   end

   initial begin
      iv8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0; ci8 = 1'b0;
      iv4 = 1'b0; or4 = 1'b1; a4 = '0; b4 = '0; ci4 = 1'b0;
      test_reset();
      test_basic();
      test_carry();
      test_backpressure();
      test_reset_mid_run();
      test_random8(200);
      test_random4(200);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
